axil2lb_buf: RTL

AXI4-Lite slave to local-bus bridge with a parametrised posted-write buffer and a read timeout. AW/W beats are captured, pushed into a write FIFO and acknowledged with B immediately. The FIFO then drains to the local bus under lb wready flow control. Reads are ordered behind buffered writes and return SLVERR if the local bus never answers. It sits between the AXI-Lite interconnect and a generated register map, replacing the unbuffered bridge where the register side can stall.

---
 rtl/axil2lb_pkg.sv | 20 ++
 rtl/lb_wfifo.sv | 54 +++++
 rtl/axil2lb_buf.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/axil2lb_pkg.sv
// Shared types for the AXI-Lite to local-bus bridge: response codes, read FSM
// states and the posted-write buffer entry, sized for the widest supported bus.
package axil2lb_pkg;

  localparam int MAX_ADDR_W = 32;
  localparam int MAX_DATA_W = 64;
  localparam int MAX_STRB_W = MAX_DATA_W / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} rd_state_t;

  typedef struct packed {
    logic [MAX_ADDR_W-1:0] addr;
    logic [MAX_DATA_W-1:0] data;
    logic [MAX_STRB_W-1:0] strb;
  } wr_entry_t;

endpackage

// File: rtl/lb_wfifo.sv
// Posted-write buffer: DEPTH-entry synchronous FIFO of write entries.
// The head reads as zero while empty so the local-bus outputs idle at 0.
module lb_wfifo
  import axil2lb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  wr_entry_t        din,
  input  logic             pop,
  output wr_entry_t        dout,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  localparam int PTR_W = $clog2(DEPTH);

  wr_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/axil2lb_buf.sv
// AXI4-Lite slave to local-bus bridge with posted-write buffer and read timeout.
// Writes are acknowledged on entry to the buffer; reads wait until it is empty.
module axil2lb_buf
  import axil2lb_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 32,
  parameter int WFIFO_DEPTH = 4,
  parameter int RD_TIMEOUT  = 255,
  localparam int STRB_W     = DATA_W / 8,
  localparam int LVL_W      = $clog2(WFIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] AXIL_AWADDR,
  input  logic [2:0]        AXIL_AWPROT,
  input  logic              AXIL_AWVALID,
  output logic              AXIL_AWREADY,
  input  logic [DATA_W-1:0] AXIL_WDATA,
  input  logic [STRB_W-1:0] AXIL_WSTRB,
  input  logic              AXIL_WVALID,
  output logic              AXIL_WREADY,
  output logic [1:0]        AXIL_BRESP,
  output logic              AXIL_BVALID,
  input  logic              AXIL_BREADY,
  input  logic [ADDR_W-1:0] AXIL_ARADDR,
  input  logic [2:0]        AXIL_ARPROT,
  input  logic              AXIL_ARVALID,
  output logic              AXIL_ARREADY,
  output logic [DATA_W-1:0] AXIL_RDATA,
  output logic [1:0]        AXIL_RRESP,
  output logic              AXIL_RVALID,
  input  logic              AXIL_RREADY,
  input  logic              wready,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic [STRB_W-1:0] wstrb,
  output logic              wen,
  output logic [ADDR_W-1:0] raddr,
  output logic              ren,
  input  logic [DATA_W-1:0] rdata,
  input  logic              rvalid,
  output logic [LVL_W-1:0]  wfifo_level,
  output logic              rd_timeout
);

  localparam int CNT_W = (RD_TIMEOUT > 0) ? $clog2(RD_TIMEOUT + 1) : 1;
  // WAIT lasts exactly RD_TIMEOUT cycles: give up on the edge where the count reaches it.
  localparam logic [CNT_W-1:0] CNT_TC = (RD_TIMEOUT > 0) ? CNT_W'(RD_TIMEOUT - 1) : '0;

  logic              active;
  logic              aw_held, w_held;
  logic [ADDR_W-1:0] aw_addr;
  logic [DATA_W-1:0] w_data;
  logic [STRB_W-1:0] w_strb;
  logic              bvalid_q;
  logic              push, pop, fifo_full, fifo_empty;
  wr_entry_t         fifo_din, fifo_head;
  rd_state_t         rd_state;
  logic [CNT_W-1:0]  rd_cnt;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        rresp_q;
  logic              unused_sig;

  assign push = aw_held && w_held && !fifo_full && !bvalid_q;
  assign pop  = !fifo_empty && wready;

  always_comb begin
    fifo_din = '0;
    fifo_din.addr[ADDR_W-1:0] = aw_addr;
    fifo_din.data[DATA_W-1:0] = w_data;
    fifo_din.strb[STRB_W-1:0] = w_strb;
  end

  lb_wfifo #(.DEPTH(WFIFO_DEPTH)) u_wfifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (wfifo_level)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      active   <= 1'b0;
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      aw_addr  <= '0;
      w_data   <= '0;
      w_strb   <= '0;
      bvalid_q <= 1'b0;
    end else begin
      active <= 1'b1;
      if (AXIL_AWVALID && AXIL_AWREADY) begin
        aw_held <= 1'b1;
        aw_addr <= AXIL_AWADDR;
      end
      if (AXIL_WVALID && AXIL_WREADY) begin
        w_held <= 1'b1;
        w_data <= AXIL_WDATA;
        w_strb <= AXIL_WSTRB;
      end
      if (push) begin
        aw_held  <= 1'b0;
        w_held   <= 1'b0;
        bvalid_q <= 1'b1;
      end else if (bvalid_q && AXIL_BREADY) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  assign AXIL_AWREADY = active && !aw_held;
  assign AXIL_WREADY  = active && !w_held;
  assign AXIL_BVALID  = bvalid_q;
  assign AXIL_BRESP   = RESP_OKAY;

  assign wen   = !fifo_empty;
  assign waddr = fifo_head.addr[ADDR_W-1:0];
  assign wdata = fifo_head.data[DATA_W-1:0];
  assign wstrb = fifo_head.strb[STRB_W-1:0];

  // A read may only start once every acknowledged write has left the buffer.
  assign AXIL_ARREADY = active && (rd_state == IDLE) && fifo_empty && !push;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_state   <= IDLE;
      rd_cnt     <= '0;
      raddr      <= '0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      rd_timeout <= 1'b0;
    end else begin
      rd_timeout <= 1'b0;
      case (rd_state)
        IDLE: if (AXIL_ARVALID && AXIL_ARREADY) begin
          raddr    <= AXIL_ARADDR;
          rd_state <= REQ;
        end
        REQ: begin
          rd_cnt   <= '0;
          rd_state <= WAIT;
        end
        WAIT: begin
          if (rvalid) begin
            rdata_q  <= rdata;
            rresp_q  <= RESP_OKAY;
            rd_state <= RESP;
          end else if ((RD_TIMEOUT > 0) && (rd_cnt == CNT_TC)) begin
            rdata_q    <= '0;
            rresp_q    <= RESP_SLVERR;
            rd_timeout <= 1'b1;
            rd_state   <= RESP;
          end else if (rd_cnt != '1) begin
            rd_cnt <= rd_cnt + 1'b1;
          end
        end
        RESP: if (AXIL_RREADY) rd_state <= IDLE;
        default: rd_state <= IDLE;
      endcase
    end
  end

  assign ren         = (rd_state == REQ);
  assign AXIL_RVALID = (rd_state == RESP);
  assign AXIL_RDATA  = rdata_q;
  assign AXIL_RRESP  = rresp_q;

  assign unused_sig = ^{AXIL_AWPROT, AXIL_ARPROT, fifo_head};

endmodule
